// File: rtl/ringosc_pkg.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
//  Module      : ringosc_pkg
//  Description : Shared types, default parameters and the per-channel
//                stage-count helper for the ring-oscillator frequency meter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ringosc_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Default parameter values for the meter top level
  localparam int DEF_NUM_OSC        = 4;
  localparam int DEF_BASE_STAGES    = 3;
  localparam int DEF_STAGE_STEP     = 2;
  localparam int DEF_DIV_LOG2       = 4;
  localparam int DEF_GATE_W         = 16;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_STAGE_DELAY_PS = 1000;

  // Number of inverting stages in channel i; odd base plus even step keeps
  // every ring odd so it always oscillates.
  function automatic int stages(input int i,
                                input int base_stages = DEF_BASE_STAGES,
                                input int stage_step  = DEF_STAGE_STEP);
    return base_stages + i * stage_step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ringosc_chain.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
//  Module      : ringosc_chain
//  Description : One enable-gated ring oscillator plus its ripple prescaler.
//                Output is forced static 0 whenever the enable is low.
//  Revision    : 1.0 - initial release
// ============================================================================
(* keep_hierarchy = "yes" *)
module ringosc_chain #(
  parameter int STAGES         = 3,
  parameter int STAGE_DELAY_PS = 1000,
  parameter int DIV_LOG2       = 4
) (
  input  logic rst_n,
  input  logic en_i,
  output logic osc_o,
  output logic div_msb_o
);

  logic                clr_n;
  logic                osc_raw;
  logic [DIV_LOG2-1:0] div_q;
  logic [DIV_LOG2-1:0] div_d;

`ifdef SYNTHESIS
  // Physical ring: one NAND (carries the enable) followed by inverters.
  // The keep attribute stops the tools from collapsing the loop.
  (* keep = "true" *) logic ring [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_nand
      assign ring[0] = ~(en_i & ring[STAGES-1]);
    end else begin : g_inv
      assign ring[g] = ~ring[g-1];
    end
  end

  assign osc_raw = ~ring[0];
`else
  // Behavioural ring: lumped equivalent of STAGES stages of STAGE_DELAY_PS
  // each, so the half period is STAGES * STAGE_DELAY_PS.
  always begin
    if (!en_i) begin
      osc_raw = 1'b0;
      @(posedge en_i);
    end
    #(STAGES * STAGE_DELAY_PS);
    if (en_i) osc_raw = ~osc_raw;
  end
`endif

  assign osc_o     = en_i & osc_raw;
  assign clr_n     = rst_n & en_i;
  assign div_msb_o = div_q[DIV_LOG2-1];

  // Next prescaler count
  always_comb begin
    div_d = div_q + DIV_LOG2'(1);
  end

  // Prescaler in the oscillator domain, cleared while the channel is off
  always_ff @(posedge osc_o or negedge clr_n) begin
    if (!clr_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule
`default_nettype wire

// File: rtl/ringosc_meter.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
//  Module      : ringosc_meter
//  Description : Bank of NUM_OSC ring oscillators with a clk-domain frequency
//                meter counting prescaled edges of the selected channel over
//                a programmable gate window.
//  Revision    : 1.0 - initial release
// ============================================================================
module ringosc_meter
  import ringosc_pkg::*;
#(
  parameter int NUM_OSC        = DEF_NUM_OSC,
  parameter int BASE_STAGES    = DEF_BASE_STAGES,
  parameter int STAGE_STEP     = DEF_STAGE_STEP,
  parameter int DIV_LOG2       = DEF_DIV_LOG2,
  parameter int GATE_W         = DEF_GATE_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int STAGE_DELAY_PS = DEF_STAGE_DELAY_PS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [$clog2(NUM_OSC)-1:0] sel_i,
  input  logic [GATE_W-1:0]          gate_cycles_i,
  input  logic                       free_run_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CNT_W-1:0]           count_o,
  output logic                       ovf_o,
  output logic                       osc_out
);

  localparam int                SEL_W       = $clog2(NUM_OSC);
  localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [GATE_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               sync3_q, sync3_d;

  logic               chan_on;
  logic               rise;
  logic               osc_mux;
  logic               msb_mux;
  logic [NUM_OSC-1:0] chan_en;
  logic [NUM_OSC-1:0] chan_osc;
  logic [NUM_OSC-1:0] chan_msb;

  // The latched channel runs for the whole measurement, or while idling
  // when free-run is requested; reset forces every ring off.
  assign chan_on = rst_n & ((state_q != IDLE) | free_run_i);

  for (genvar i = 0; i < NUM_OSC; i++) begin : g_chan
    assign chan_en[i] = chan_on & (sel_q == SEL_W'(i));

    ringosc_chain #(
      .STAGES         (stages(i, BASE_STAGES, STAGE_STEP)),
      .STAGE_DELAY_PS (STAGE_DELAY_PS),
      .DIV_LOG2       (DIV_LOG2)
    ) u_chain (
      .rst_n     (rst_n),
      .en_i      (chan_en[i]),
      .osc_o     (chan_osc[i]),
      .div_msb_o (chan_msb[i])
    );
  end

  // Select raw and prescaled outputs of the latched channel; an out-of-range
  // selection yields 0 so the measurement reports no edges.
  always_comb begin
    osc_mux = 1'b0;
    msb_mux = 1'b0;
    for (int i = 0; i < NUM_OSC; i++) begin
      if (sel_q == SEL_W'(i)) begin
        osc_mux = chan_osc[i];
        msb_mux = chan_msb[i];
      end
    end
  end

  // Two-flop synchroniser plus one history flop for rising-edge detection
  always_comb begin
    sync1_d = msb_mux;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  assign rise = sync2_q & ~sync3_q;

  // Synchroniser and edge-detector registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  // Measurement FSM next state and datapath
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gate_d  = gate_q;
    timer_d = timer_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETTLE;
          sel_d   = sel_i;
          gate_d  = gate_cycles_i;
          timer_d = SETTLE_LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          if (gate_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = GATE;
            timer_d = gate_q - GATE_W'(1);
          end
        end else begin
          timer_d = timer_q - GATE_W'(1);
        end
      end
      GATE: begin
        if (rise) begin
          if (&count_q) ovf_d   = 1'b1;
          else          count_d = count_q + CNT_W'(1);
        end
        if (abort_i) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q - GATE_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Measurement FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gate_q  <= '0;
      timer_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
      timer_q <= timer_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign osc_out = osc_mux;

endmodule
`default_nettype wire

// File: doc/ringosc_meter.md
# ringosc_meter

Parametrised ring-oscillator bank with an on-chip frequency meter: NUM_OSC enable-gated ring oscillators of increasing stage count, a per-channel prescaler in the oscillator domain, and a clk-domain measurement FSM. The FSM counts prescaled edges of one selected oscillator over a programmable gate window. It replaces the single fixed 3-stage oscillator in the top level, and feeds result registers and the raw selected oscillator to the pad mux.

## Interface
Parameters:
- NUM_OSC, 4: number of oscillator channels.
- BASE_STAGES, 3: inverting stages in channel 0. Must be odd.
- STAGE_STEP, 2: extra stages per subsequent channel; channel i has BASE_STAGES + i·STAGE_STEP stages. Must be even.
- DIV_LOG2, 4: prescaler width; oscillator is divided by 2^DIV_LOG2 before crossing.
- GATE_W, 16: gate-window counter width, in clk cycles.
- CNT_W, 16: result counter width.
- SETTLE_CYCLES, 4: clk cycles between oscillator enable and gate open.
- STAGE_DELAY_PS, 1000: per-stage delay; simulation model only.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle request to start a measurement.
- abort_i  in  1  cancel the measurement in progress.
- sel_i  in  $clog2(NUM_OSC)  channel to measure; sampled with start_i.
- gate_cycles_i  in  GATE_W  gate length in clk cycles; sampled with start_i.
- free_run_i  in  1  keep the selected oscillator enabled while IDLE.
- busy_o  out  1  measurement in progress.
- done_o  out  1  one-cycle pulse when the result is valid.
- count_o  out  CNT_W  prescaled edge count of the last completed measurement.
- ovf_o  out  1  count saturated during the last measurement.
- osc_out  out  1  raw output of the selected, enabled oscillator; 0 when disabled.

## Operation
- Each channel is a NAND-enabled ring (enable=0 forces the ring static, output 0). At most one channel is enabled at a time, and it is the latched selection.
- Channel enable = (state ≠ IDLE) or free_run_i, applied to the latched sel.
- Prescaler: DIV_LOG2-bit up-counter clocked by the oscillator, asynchronously cleared by rst_n low or by channel enable low. Its MSB crosses into clk through a 2-FF synchroniser, and a rising-edge detector follows.
- FSM states:
  - IDLE → SETTLE on start_i. On entry, latch sel_i and gate_cycles_i, and clear count and ovf.
  - SETTLE counts SETTLE_CYCLES cycles, then → GATE. If the latched gate is 0, → DONE instead and report count 0.
  - GATE counts latched gate_cycles cycles. Each detected rising edge increments count, saturating at 2^CNT_W−1 with ovf_o set. At the end → DONE.
  - DONE lasts one cycle with done_o=1, then → IDLE.
- abort_i in SETTLE or GATE → IDLE next cycle. No done_o. count_o/ovf_o hold the partial value. abort_i in IDLE or DONE is ignored.
- start_i while busy_o=1 is ignored. start_i and abort_i together in IDLE: start wins.
- sel_i ≥ NUM_OSC at start: measurement runs with no channel enabled and reports count 0.
- Reset values: busy_o=0, done_o=0, count_o=0, ovf_o=0, osc_out=0, state IDLE, all rings disabled.
- Reset mid-measurement: immediate return to IDLE, all outputs to reset values, no done_o.

## Timing
- start_i high at edge k: busy_o=1 from k+1.
- Gate opens at k+1+SETTLE_CYCLES and covers exactly gate_cycles clk cycles.
- done_o at cycle k+1+SETTLE_CYCLES+gate_cycles. busy_o drops the cycle after done_o.
- count_o is final in the done_o cycle and is held until the next accepted start.
- Synchroniser latency is 2 cycles; edges in flight at gate close are not counted. Tolerance is ±1 count.
- Valid range: f_osc / 2^DIV_LOG2 < f_clk / 2. Above this, counts are undefined.

## Structure
- Package ringosc_pkg holds:
  - state enum {IDLE, SETTLE, GATE, DONE};
  - default parameter constants;
  - the stage-count function stages(i).
- Sub-module ringosc_chain (param STAGES, STAGE_DELAY_PS) contains one ring and its prescaler.
  - Synthesis: keep/keep_hierarchy attributes; combinational-loop lint waived locally.
  - Simulation: each stage carries #STAGE_DELAY_PS.
- Top generates NUM_OSC chains, the output mux, the synchroniser, the edge detector and the FSM.

## Test plan
Conditions: clk 100 MHz, STAGE_DELAY_PS=1000, defaults.
- Reset then idle: all outputs 0, osc_out static 0, no ring toggling for 1 µs.
- sel=0 (3 stages, 6 ns period), gate=960: done_o at start+1+4+960 cycles, count_o=100±1, ovf_o=0.
- sel=3 (9 stages, 18 ns period), gate=960: count_o=33±1. osc_out toggles only while busy.
- CNT_W=4, sel=0, gate=960: count_o=15, ovf_o=1.
- abort_i 100 cycles into GATE: busy_o=0 next cycle, no done_o. A second start_i during the original measurement is ignored.
- gate=0: done_o at start+5, count_o=0. rst_n low mid-GATE: all outputs 0 immediately.
